// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a synchronous-read instruction ROM: issues addresses,
// tracks the single outstanding read and buffers returned words for decode.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_50,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   r_fetch_pc;
   logic          r_req_q;
   logic [31:0]   r_req_pc_q;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_fifo_inst [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [CW:0]   w_occ;
   logic [1:0]    w_unused_rpc_lsb;

   assign w_unused_rpc_lsb = redirect_pc[1:0];

   assign mem_addr  = r_fetch_pc;
   assign out_valid = (r_count != '0);
   assign out_pc    = out_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
   assign out_inst  = out_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;

   assign w_pop  = out_valid && out_ready;
   assign w_push = r_req_q && !redirect_valid;
   // Credit check counts the read already in flight so a response always finds a free slot.
   assign w_occ   = {1'b0, r_count} + (CW+1)'(r_req_q) - (CW+1)'(w_pop);
   assign w_issue = fetch_en && !redirect_valid && (w_occ < (CW+1)'(DEPTH));

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_req_q    <= 1'b0;
         r_req_pc_q <= 32'h0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_req_q    <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_req_q <= w_issue;
         if (w_issue) begin
            r_req_pc_q <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk_50) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= r_req_pc_q;
         r_fifo_inst[r_wr_ptr] <= mem_inst;
      end
   end

   a_no_overflow: assert property (@(posedge clk_50) disable iff (rst)
      !(w_push && r_count == CW'(DEPTH)));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed cycle table, hand corner cases and a
// randomized run checked against an in-order program-stream model.
module tb_imem_fetch_ctrl;

   logic        clk_50 = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk_50(clk_50), .rst(rst), .fetch_en(fetch_en), .mem_addr(mem_addr),
      .mem_inst(mem_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
   );

   always #10 clk_50 = ~clk_50;

   logic [31:0] rom [1024];
   always @(posedge clk_50) mem_inst <= rom[mem_addr[11:2]];

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   typedef struct {
      bit          fe;
      bit          rdy;
      bit          rv;
      logic [31:0] rpc;
      bit          ev;
      logic [31:0] epc;
   } vec_t;

   vec_t tbl [43];

   function automatic vec_t mk(bit fe, bit rdy, bit rv, logic [31:0] rpc, bit ev, logic [31:0] epc);
      vec_t v;
      v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
      return v;
   endfunction

   function automatic logic [31:0] rom_at(logic [31:0] pc);
      return rom[pc[11:2]];
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_pc;
      logic [31:0] prev_pc;
      bit          prev_v, prev_rdy, prev_rv, pop;
      int          npops;

      for (int i = 0; i < 1024; i++) rom[i] = (32'(i) * 32'h0100_0193) ^ 32'h00A5_0013;
      rom[2]  = 32'h0000_0013;
      rom[5]  = 32'hff81_0113;
      rom[10] = 32'h0000_0513;

      // In-order stream: (fetch_en, out_ready, redirect, target) -> expected head
      for (int c = 0; c < 2; c++)   tbl[c] = mk(1, 1, 0, 0, 0, 0);
      for (int c = 2; c < 4; c++)   tbl[c] = mk(1, 1, 0, 0, 1, 32'(4 * (c - 2)));
      for (int c = 4; c < 9; c++)   tbl[c] = mk(1, 0, 0, 0, 1, 8);
      tbl[9] = mk(1, 1, 0, 0, 1, 8);
      for (int c = 10; c < 20; c++) tbl[c] = mk(1, 1, 0, 0, 1, 32'(4 * (c - 7)));
      tbl[20] = mk(1, 0, 1, 40, 1, 52);
      for (int c = 21; c < 23; c++) tbl[c] = mk(1, 1, 0, 0, 0, 0);
      for (int c = 23; c < 31; c++) tbl[c] = mk(1, 1, 0, 0, 1, 32'(40 + 4 * (c - 23)));
      tbl[30].rv = 1; tbl[30].rpc = 118;
      for (int c = 31; c < 33; c++) tbl[c] = mk(1, 1, 0, 0, 0, 0);
      for (int c = 33; c < 35; c++) tbl[c] = mk(1, 1, 0, 0, 1, 32'(116 + 4 * (c - 33)));
      tbl[35] = mk(0, 1, 0, 0, 1, 124);
      tbl[36] = mk(0, 1, 0, 0, 1, 128);
      for (int c = 37; c < 39; c++) tbl[c] = mk(0, 1, 0, 0, 0, 0);
      for (int c = 39; c < 41; c++) tbl[c] = mk(1, 1, 0, 0, 0, 0);
      for (int c = 41; c < 43; c++) tbl[c] = mk(1, 0, 0, 0, 1, 132);

      rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      repeat (3) @(negedge clk_50);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", out_pc, 32'h0);
      chk("rst_inst", out_inst, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      rst = 1'b0;

      for (int c = 0; c < 43; c++) begin
         chk($sformatf("row%0d_valid", c), 32'(out_valid), 32'(tbl[c].ev));
         if (tbl[c].ev) begin
            chk($sformatf("row%0d_pc", c), out_pc, tbl[c].epc);
            chk($sformatf("row%0d_inst", c), out_inst, rom_at(tbl[c].epc));
         end
         fetch_en = tbl[c].fe; out_ready = tbl[c].rdy;
         redirect_valid = tbl[c].rv; redirect_pc = tbl[c].rpc;
         @(negedge clk_50);
      end

      // FIFO full under back-pressure, then asynchronous reset between edges
      chk("full_valid", 32'(out_valid), 32'd1);
      chk("full_pc", out_pc, 32'd132);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_pc", out_pc, 32'h0);
      chk("arst_addr", mem_addr, 32'h0);
      @(negedge clk_50);
      rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("restart%0d_addr", k), mem_addr, 32'(4 * k));
         chk($sformatf("restart%0d_valid", k), 32'(out_valid), (k >= 2) ? 32'd1 : 32'd0);
         if (k >= 2) chk($sformatf("restart%0d_pc", k), out_pc, 32'(4 * (k - 2)));
         @(negedge clk_50);
      end

      // Redirect to a misaligned top-of-space target: aligned, then wraps to 0
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk_50);
      redirect_valid = 1'b0;
      chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
      for (int k = 1; k <= 4; k++) begin
         if (k < 3) chk($sformatf("wrap%0d_valid", k), 32'(out_valid), 32'd0);
         else begin
            exp_pc = (k == 3) ? 32'hFFFF_FFFC : 32'h0;
            chk($sformatf("wrap%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("wrap%0d_pc", k), out_pc, exp_pc);
            chk($sformatf("wrap%0d_inst", k), out_inst, rom_at(exp_pc));
         end
         @(negedge clk_50);
      end

      // Random run: every accepted instruction must be the next one of the program stream
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      exp_pc = 32'h100;
      @(negedge clk_50);
      prev_v = 0; prev_rdy = 0; prev_rv = 1; prev_pc = 0; npops = 0;
      for (int c = 0; c < 3000; c++) begin
         if (prev_v && !prev_rdy && !prev_rv) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_pc", out_pc, prev_pc);
         end
         fetch_en       = ($urandom % 8) != 0;
         out_ready      = ($urandom % 4) != 0;
         redirect_valid = ($urandom % 32) == 0;
         redirect_pc    = $urandom;
         pop = out_valid && out_ready;
         if (pop) begin
            chk("rand_pc", out_pc, exp_pc);
            chk("rand_inst", out_inst, rom_at(exp_pc));
            exp_pc = exp_pc + 32'd4;
            npops++;
         end
         if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
         prev_v = out_valid; prev_rdy = out_ready; prev_rv = redirect_valid; prev_pc = out_pc;
         @(negedge clk_50);
      end
      chk("rand_progress", 32'(npops >= 1000), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
